// File: rtl/master_req_tracker.sv
// Per-master request tracker: holds one outstanding transaction, presents it to the
// slave-side ack arbiters, then collects the read data from the addressed slave.
module master_req_tracker #(
   parameter int AW      = 8,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m_req,
   input  logic          m_cmd,
   input  logic [AW-1:0] m_addr,
   input  logic [DW-1:0] m_wdata,
   output logic          m_busy,
   output logic          m_ack,
   output logic          m_resp,
   output logic [DW-1:0] m_rdata,
   output logic          m_err,
   output logic [1:0]    req_stat,
   output logic          sfor,
   output logic          req_cmd,
   output logic [AW-1:0] req_addr,
   output logic [DW-1:0] req_wdata,
   input  logic          ack_in,
   input  logic          resp_in0,
   input  logic          resp_in1,
   input  logic [DW-1:0] rdata_in0,
   input  logic [DW-1:0] rdata_in1
);

   typedef enum logic [1:0] {
      S_NO_REQ = 2'd0,
      S_WAIT   = 2'd1,
      S_W_ACK  = 2'd2,
      S_W_DATA = 2'd3
   } state_t;

   localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            ack_nxt, resp_nxt, err_nxt;
   logic            latch, capture;
   logic            expired;
   logic            resp_sel;
   logic [DW-1:0]   rdata_sel;

   // Only the slave the request was sent to may complete it.
   assign resp_sel  = sfor ? resp_in1 : resp_in0;
   assign rdata_sel = sfor ? rdata_in1 : rdata_in0;

   // A TIMEOUT of 0 disables the abort path entirely.
   assign expired = (TIMEOUT != 0) && (cnt == CNT_LAST);

   assign req_stat = state;
   assign m_busy   = (state != S_NO_REQ);

   // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ack_nxt   = 1'b0;
      resp_nxt  = 1'b0;
      err_nxt   = 1'b0;
      latch     = 1'b0;
      capture   = 1'b0;
      unique case (state)
         S_NO_REQ: begin
            if (m_req) begin
               latch     = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            state_nxt = S_W_ACK;
            cnt_nxt   = '0;
         end
         S_W_ACK: begin
            // An ack arriving on the expiry cycle takes priority over the abort.
            if (ack_in) begin
               ack_nxt   = 1'b1;
               state_nxt = req_cmd ? S_NO_REQ : S_W_DATA;
               cnt_nxt   = '0;
            end else if (expired) begin
               err_nxt   = 1'b1;
               state_nxt = S_NO_REQ;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_W_DATA: begin
            if (resp_sel) begin
               capture   = 1'b1;
               resp_nxt  = 1'b1;
               state_nxt = S_NO_REQ;
            end else if (expired) begin
               err_nxt   = 1'b1;
               state_nxt = S_NO_REQ;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: state_nxt = S_NO_REQ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_NO_REQ;
         cnt       <= '0;
         m_ack     <= 1'b0;
         m_resp    <= 1'b0;
         m_err     <= 1'b0;
         m_rdata   <= '0;
         sfor      <= 1'b0;
         req_cmd   <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         m_ack  <= ack_nxt;
         m_resp <= resp_nxt;
         m_err  <= err_nxt;
         if (latch) begin
            req_cmd   <= m_cmd;
            req_addr  <= m_addr;
            req_wdata <= m_wdata;
            sfor      <= m_addr[AW-1];
         end
         if (capture) begin
            m_rdata <= rdata_sel;
         end
      end
   end

endmodule

// File: tb/tb_master_req_tracker.sv
// Self-checking bench for master_req_tracker: directed transactions with a scoreboard
// of expected m_ack/m_resp/m_err pulses, plus direct checks of state and latched fields.
module tb_master_req_tracker;

   localparam int AW = 8;
   localparam int DW = 32;

   localparam logic [2:0] EV_ACK  = 3'b001;
   localparam logic [2:0] EV_RESP = 3'b010;
   localparam logic [2:0] EV_ERR  = 3'b100;

   typedef struct {
      logic [2:0]    kind;
      logic [DW-1:0] data;
   } ev_t;

   logic          clk;
   logic          reset;
   logic          m_req;
   logic          m_cmd;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_busy;
   logic          m_ack;
   logic          m_resp;
   logic [DW-1:0] m_rdata;
   logic          m_err;
   logic [1:0]    req_stat;
   logic          sfor;
   logic          req_cmd;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          ack_in;
   logic          resp_in0;
   logic          resp_in1;
   logic [DW-1:0] rdata_in0;
   logic [DW-1:0] rdata_in1;

   int  n_vec = 0;
   int  n_err = 0;
   ev_t sb[$];
   ev_t mon_e;

   master_req_tracker #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .m_req     (m_req),
      .m_cmd     (m_cmd),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_busy    (m_busy),
      .m_ack     (m_ack),
      .m_resp    (m_resp),
      .m_rdata   (m_rdata),
      .m_err     (m_err),
      .req_stat  (req_stat),
      .sfor      (sfor),
      .req_cmd   (req_cmd),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .ack_in    (ack_in),
      .resp_in0  (resp_in0),
      .resp_in1  (resp_in1),
      .rdata_in0 (rdata_in0),
      .rdata_in1 (rdata_in1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [2:0] k, input logic [DW-1:0] d);
      ev_t e;
      e.kind = k;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic drain(input string tag);
      check(tag, 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   // Drives one request and walks it through WAIT into W_ACK.
   task automatic issue(input logic cmd, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      m_req   = 1'b1;
      m_cmd   = cmd;
      m_addr  = addr;
      m_wdata = wd;
      tick();
      m_req = 1'b0;
      check("stat_wait", req_stat, 2'd1);
      check("sfor_latch", sfor, addr[AW-1]);
      check("addr_latch", req_addr, addr);
      check("cmd_latch", req_cmd, cmd);
      check("wdata_latch", req_wdata, wd);
      tick();
      check("stat_w_ack", req_stat, 2'd2);
   endtask

   // Every pulse observed must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!reset && (m_ack || m_resp || m_err)) begin
         if (sb.size() == 0) begin
            check("spurious_evt", {m_err, m_resp, m_ack}, 3'b000);
         end else begin
            mon_e = sb.pop_front();
            check("evt_kind", {m_err, m_resp, m_ack}, mon_e.kind);
            if (mon_e.kind == EV_RESP) check("evt_rdata", m_rdata, mon_e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      m_req     = 1'b0;
      m_cmd     = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;
      ack_in    = 1'b0;
      resp_in0  = 1'b0;
      resp_in1  = 1'b0;
      rdata_in0 = '0;
      rdata_in1 = '0;
      tick(2);
      reset = 1'b0;
      tick();

      check("rst_stat", req_stat, 2'd0);
      check("rst_busy", m_busy, 1'b0);
      check("rst_rdata", m_rdata, 32'h0);
      check("rst_sfor", sfor, 1'b0);
      check("rst_addr", req_addr, 8'h00);
      check("rst_pulses", {m_err, m_resp, m_ack}, 3'b000);

      // Write to S1, acked on the third edge after the request.
      issue(1'b1, 8'h80, 32'hA5A5_0001);
      check("t1_busy", m_busy, 1'b1);
      ack_in = 1'b1;
      push(EV_ACK, '0);
      tick();
      ack_in = 1'b0;
      check("t1_stat_done", req_stat, 2'd0);
      check("t1_busy_done", m_busy, 1'b0);
      tick();
      drain("t1_drain");

      // Read from S0.
      issue(1'b0, 8'h10, 32'h0);
      ack_in = 1'b1;
      push(EV_ACK, '0);
      tick();
      ack_in = 1'b0;
      check("t2_stat_w_data", req_stat, 2'd3);
      resp_in0  = 1'b1;
      rdata_in0 = 32'hDEAD_BEEF;
      push(EV_RESP, 32'hDEAD_BEEF);
      tick();
      resp_in0  = 1'b0;
      rdata_in0 = 32'h0;
      check("t2_stat_done", req_stat, 2'd0);
      check("t2_rdata", m_rdata, 32'hDEAD_BEEF);
      tick(2);
      check("t2_rdata_hold", m_rdata, 32'hDEAD_BEEF);
      drain("t2_drain");

      // Read from S0, wrong slave responds first.
      issue(1'b0, 8'h20, 32'h0);
      ack_in = 1'b1;
      push(EV_ACK, '0);
      tick();
      ack_in    = 1'b0;
      resp_in1  = 1'b1;
      rdata_in1 = 32'h1111_1111;
      tick();
      resp_in1 = 1'b0;
      check("t3_wrong_stat", req_stat, 2'd3);
      check("t3_wrong_rdata", m_rdata, 32'hDEAD_BEEF);
      resp_in0  = 1'b1;
      rdata_in0 = 32'hCAFE_F00D;
      push(EV_RESP, 32'hCAFE_F00D);
      tick();
      resp_in0 = 1'b0;
      check("t3_stat_done", req_stat, 2'd0);
      check("t3_rdata", m_rdata, 32'hCAFE_F00D);
      tick();
      drain("t3_drain");

      // Read from S1, S0 responds first.
      issue(1'b0, 8'hC4, 32'h0);
      ack_in = 1'b1;
      push(EV_ACK, '0);
      tick();
      ack_in    = 1'b0;
      resp_in0  = 1'b1;
      rdata_in0 = 32'h2222_2222;
      tick();
      resp_in0 = 1'b0;
      check("t3b_wrong_stat", req_stat, 2'd3);
      resp_in1  = 1'b1;
      rdata_in1 = 32'h0BAD_F00D;
      push(EV_RESP, 32'h0BAD_F00D);
      tick();
      resp_in1 = 1'b0;
      check("t3b_rdata", m_rdata, 32'h0BAD_F00D);
      tick();
      drain("t3b_drain");

      // Timeout in W_ACK: four cycles there, then abort.
      issue(1'b1, 8'h40, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_stat_hold", req_stat, 2'd2);
      end
      push(EV_ERR, '0);
      tick();
      check("t4_stat_abort", req_stat, 2'd0);
      check("t4_busy_abort", m_busy, 1'b0);
      tick();
      drain("t4_drain");

      // Ack on the expiry cycle wins.
      issue(1'b1, 8'h41, 32'h0);
      tick(3);
      ack_in = 1'b1;
      push(EV_ACK, '0);
      tick();
      ack_in = 1'b0;
      check("t4b_stat", req_stat, 2'd0);
      tick();
      drain("t4b_drain");

      // Timeout in W_DATA; counter restarts on entry.
      issue(1'b0, 8'h42, 32'h0);
      tick(2);
      ack_in = 1'b1;
      push(EV_ACK, '0);
      tick();
      ack_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t4c_stat_hold", req_stat, 2'd3);
         tick();
      end
      check("t4c_stat_last", req_stat, 2'd3);
      push(EV_ERR, '0);
      tick();
      check("t4c_stat_abort", req_stat, 2'd0);
      check("t4c_rdata_kept", m_rdata, 32'h0BAD_F00D);
      tick();
      drain("t4c_drain");

      // Response on the expiry cycle wins.
      issue(1'b0, 8'h43, 32'h0);
      ack_in = 1'b1;
      push(EV_ACK, '0);
      tick();
      ack_in = 1'b0;
      tick(3);
      resp_in0  = 1'b1;
      rdata_in0 = 32'h5A5A_5A5A;
      push(EV_RESP, 32'h5A5A_5A5A);
      tick();
      resp_in0 = 1'b0;
      check("t4d_stat", req_stat, 2'd0);
      check("t4d_rdata", m_rdata, 32'h5A5A_5A5A);
      tick();
      drain("t4d_drain");

      // Ack during WAIT is ignored.
      m_req  = 1'b1;
      m_cmd  = 1'b1;
      m_addr = 8'h05;
      tick();
      m_req = 1'b0;
      check("t5_stat_wait", req_stat, 2'd1);
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      check("t5_stat_w_ack", req_stat, 2'd2);
      tick();
      check("t5_still_w_ack", req_stat, 2'd2);
      ack_in = 1'b1;
      push(EV_ACK, '0);
      tick();
      ack_in = 1'b0;
      check("t5_stat_done", req_stat, 2'd0);
      tick();
      drain("t5_drain");

      // Acks and responses while idle produce nothing.
      ack_in   = 1'b1;
      resp_in0 = 1'b1;
      resp_in1 = 1'b1;
      tick();
      ack_in   = 1'b0;
      resp_in0 = 1'b0;
      resp_in1 = 1'b0;
      tick();
      check("t5_idle_stat", req_stat, 2'd0);
      check("t5_idle_rdata", m_rdata, 32'h5A5A_5A5A);
      drain("t5_idle_drain");

      // m_req held during W_DATA is not relatched; it is taken once idle again.
      issue(1'b0, 8'h08, 32'h0);
      ack_in = 1'b1;
      push(EV_ACK, '0);
      tick();
      ack_in  = 1'b0;
      m_req   = 1'b1;
      m_cmd   = 1'b1;
      m_addr  = 8'hF0;
      m_wdata = 32'h0000_0077;
      tick();
      check("t5b_stat", req_stat, 2'd3);
      check("t5b_addr_kept", req_addr, 8'h08);
      check("t5b_cmd_kept", req_cmd, 1'b0);
      check("t5b_sfor_kept", sfor, 1'b0);
      resp_in0  = 1'b1;
      rdata_in0 = 32'h1234_5678;
      push(EV_RESP, 32'h1234_5678);
      tick();
      resp_in0 = 1'b0;
      check("t5b_stat_done", req_stat, 2'd0);
      check("t5b_addr_still", req_addr, 8'h08);
      tick();
      m_req = 1'b0;
      check("t5b_relatch_stat", req_stat, 2'd1);
      check("t5b_relatch_addr", req_addr, 8'hF0);
      check("t5b_relatch_sfor", sfor, 1'b1);
      check("t5b_relatch_wdata", req_wdata, 32'h0000_0077);
      tick();
      ack_in = 1'b1;
      push(EV_ACK, '0);
      tick();
      ack_in = 1'b0;
      check("t5b_write_done", req_stat, 2'd0);
      tick();
      drain("t5b_drain");

      // Reset in the middle of a read.
      issue(1'b0, 8'h90, 32'h0000_00AB);
      ack_in = 1'b1;
      push(EV_ACK, '0);
      tick();
      ack_in = 1'b0;
      check("t6_stat_w_data", req_stat, 2'd3);
      tick();
      reset    = 1'b1;
      resp_in1 = 1'b1;
      #1;
      check("t6_rst_stat", req_stat, 2'd0);
      check("t6_rst_busy", m_busy, 1'b0);
      check("t6_rst_rdata", m_rdata, 32'h0);
      check("t6_rst_sfor", sfor, 1'b0);
      check("t6_rst_addr", req_addr, 8'h00);
      check("t6_rst_wdata", req_wdata, 32'h0);
      tick(2);
      resp_in1 = 1'b0;
      reset    = 1'b0;
      tick();
      check("t6_post_stat", req_stat, 2'd0);
      drain("t6_rst_drain");
      issue(1'b1, 8'h33, 32'h0000_FEED);
      ack_in = 1'b1;
      push(EV_ACK, '0);
      tick();
      ack_in = 1'b0;
      check("t6_after_stat", req_stat, 2'd0);
      tick();
      drain("t6_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
